// File: rtl/instr_mem_loader_pkg.sv
// ============================================================================
// Module : instr_mem_loader_pkg
// Brief  : Shared memory geometry and loader state encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package instr_mem_loader_pkg;

  localparam int ADDR_W    = 20;
  localparam int DATA_W    = 16;
  localparam int VEC_WORDS = 32;
  localparam int PROG_BASE = VEC_WORDS;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/instr_mem_loader_if.sv
// ============================================================================
// Module : instr_mem_loader_if
// Brief  : Control, word stream and instruction-memory write bundle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface instr_mem_loader_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);

  logic              start;
  logic              vec_mode;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              fetch_hold;
  logic              done;
  logic              error;
  logic [ADDR_W-1:0] word_count;

  modport master (
    output start, vec_mode, in_valid, in_data, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata, fetch_hold, done, error, word_count
  );

  modport slave (
    input  start, vec_mode, in_valid, in_data, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata, fetch_hold, done, error, word_count
  );

endinterface

`default_nettype wire

// File: rtl/instr_mem_loader.sv
// ============================================================================
// Module : instr_mem_loader
// Brief  : Streams a program or vector image into instruction memory.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int ADDR_W    = instr_mem_loader_pkg::ADDR_W,
  parameter int DATA_W    = instr_mem_loader_pkg::DATA_W,
  parameter int VEC_WORDS = instr_mem_loader_pkg::VEC_WORDS,
  parameter int WR_CYCLES = 1
) (
  input  wire logic       clk,
  input  wire logic       reset,
  instr_mem_loader_if.slave bus
);

  localparam int C_CYC_W = 4;

  loader_state_t     r_state;
  loader_state_t     w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_limit;
  logic [ADDR_W-1:0] r_count;
  logic [DATA_W-1:0] r_wdata;
  logic [C_CYC_W-1:0] r_cyc;
  logic              r_last;
  logic              r_vec;
  logic              r_hold;
  logic              r_done;
  logic              r_error;

  logic w_can_start;
  logic w_start;
  logic w_accept;
  logic w_cyc_last;

  assign w_can_start = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR);
  assign w_start     = w_can_start && bus.start;
  assign w_accept    = (r_state == ST_LOAD) && bus.in_valid;
  assign w_cyc_last  = (r_state == ST_WRITE) && (r_cyc == C_CYC_W'(WR_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: if (bus.start) w_state_next = ST_LOAD;
      ST_LOAD:                  if (bus.in_valid) w_state_next = ST_WRITE;
      ST_WRITE: begin
        if (w_cyc_last) begin
          if (r_last)                 w_state_next = ST_DONE;
          else if (r_addr == r_limit) w_state_next = ST_ERR;
          else                        w_state_next = ST_LOAD;
        end
      end
      default:                  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr  <= '0;
      r_limit <= '0;
      r_count <= '0;
      r_wdata <= '0;
      r_cyc   <= '0;
      r_last  <= 1'b0;
      r_vec   <= 1'b0;
      r_hold  <= 1'b1;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else if (w_start) begin
      r_addr  <= bus.vec_mode ? '0 : ADDR_W'(VEC_WORDS);
      r_limit <= bus.vec_mode ? ADDR_W'(VEC_WORDS - 1) : '1;
      r_vec   <= bus.vec_mode;
      r_count <= '0;
      r_hold  <= 1'b1;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else if (w_accept) begin
      r_wdata <= bus.in_data;
      r_last  <= bus.in_last;
      r_cyc   <= '0;
    end else if (r_state == ST_WRITE) begin
      if (w_cyc_last) begin
        r_count <= r_count + ADDR_W'(1);
        if (r_last) begin
          r_done <= 1'b1;
          // A vector image is followed by a program image before fetch may run.
          r_hold <= r_vec;
        end else if (r_addr == r_limit) begin
          r_error <= 1'b1;
          r_hold  <= 1'b1;
        end else begin
          r_addr <= r_addr + ADDR_W'(1);
        end
      end else begin
        r_cyc <= r_cyc + C_CYC_W'(1);
      end
    end
  end

  assign bus.in_ready   = (r_state == ST_LOAD);
  assign bus.mem_we     = (r_state == ST_WRITE);
  assign bus.mem_addr   = r_addr;
  assign bus.mem_wdata  = r_wdata;
  assign bus.fetch_hold = r_hold;
  assign bus.done       = r_done;
  assign bus.error      = r_error;
  assign bus.word_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
// ============================================================================
// Module : tb_instr_mem_loader
// Brief  : Directed self-checking bench for the instruction memory loader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_instr_mem_loader;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  logic [ADDR_W-1:0] wa[$];
  logic [DATA_W-1:0] wd[$];
  logic              prev_we;

  instr_mem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if1 ();
  instr_mem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if2 ();

  instr_mem_loader #(.WR_CYCLES(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (if1.slave)
  );

  instr_mem_loader #(.WR_CYCLES(6)) dut6 (
    .clk   (clk),
    .reset (reset),
    .bus   (if2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each rising edge of mem_we marks one distinct word write.
  always @(negedge clk) begin
    if (if1.mem_we && !prev_we) begin
      wa.push_back(if1.mem_addr);
      wd.push_back(if1.mem_wdata);
    end
    prev_we = if1.mem_we;
  end

  task automatic pulse_start(input logic vm);
    if1.start = 1'b1;
    if1.vec_mode = vm;
    @(posedge clk); #1;
    if1.start = 1'b0;
  endtask

  task automatic send_word(input logic [DATA_W-1:0] d, input logic l);
    int t;
    t = 0;
    if1.in_valid = 1'b1;
    if1.in_data  = d;
    if1.in_last  = l;
    @(negedge clk);
    while (!if1.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_tests++;
    if (if1.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_word_timeout data=%h in_ready=%b required=1", d, if1.in_ready);
    end
    @(posedge clk); #1;
    if1.in_valid = 1'b0;
  endtask

  task automatic wait_end();
    int t;
    t = 0;
    while (!(if1.done || if1.error) && t < 60) begin
      @(posedge clk); #1;
      t++;
    end
    n_tests++;
    if ((if1.done || if1.error) !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_end_timeout done=%b error=%b required=either", if1.done, if1.error);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({if1.in_ready, if1.mem_we, if1.fetch_hold, if1.done, if1.error} !== 5'b00100) begin
      n_fail++;
      $display("FAIL reset_flags got=%b required=00100",
               {if1.in_ready, if1.mem_we, if1.fetch_hold, if1.done, if1.error});
    end
    n_tests++;
    if ({if1.mem_addr, if1.mem_wdata, if1.word_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_values addr=%h wdata=%h count=%0d required=0",
               if1.mem_addr, if1.mem_wdata, if1.word_count);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_program_load();
    logic [DATA_W-1:0] exp_d [3];
    exp_d = '{16'hA001, 16'hA002, 16'hA003};
    wa.delete(); wd.delete();
    pulse_start(1'b0);
    for (int i = 0; i < 3; i++) send_word(exp_d[i], i == 2);
    wait_end();
    n_tests++;
    if (wa.size() !== 3) begin
      n_fail++;
      $display("FAIL prog_write_count got=%0d required=3", wa.size());
    end
    for (int i = 0; i < 3 && i < wa.size(); i++) begin
      n_tests++;
      if (wa[i] !== 20'(32 + i) || wd[i] !== exp_d[i]) begin
        n_fail++;
        $display("FAIL prog_write%0d addr=%0d data=%h required addr=%0d data=%h",
                 i, wa[i], wd[i], 32 + i, exp_d[i]);
      end
    end
    n_tests++;
    if ({if1.done, if1.error, if1.fetch_hold} !== 3'b100 || if1.word_count !== 20'd3) begin
      n_fail++;
      $display("FAIL prog_end done/err/hold=%b count=%0d required 100 count=3",
               {if1.done, if1.error, if1.fetch_hold}, if1.word_count);
    end
  endtask

  task automatic test_vector_region();
    int ok;
    int rdy_seen;
    // Exactly-fitting vector image: last word lands on the region limit.
    wa.delete(); wd.delete();
    pulse_start(1'b1);
    n_tests++;
    if (if1.fetch_hold !== 1'b1 || if1.done !== 1'b0) begin
      n_fail++;
      $display("FAIL vec_start hold=%b done=%b required hold=1 done=0", if1.fetch_hold, if1.done);
    end
    for (int i = 0; i < 32; i++) send_word(16'(16'hB000 + i), i == 31);
    wait_end();
    ok = (wa.size() == 32);
    for (int i = 0; i < 32 && i < wa.size(); i++)
      if (wa[i] !== 20'(i) || wd[i] !== 16'(16'hB000 + i)) ok = 0;
    n_tests++;
    if (ok != 1) begin
      n_fail++;
      $display("FAIL vec_fit_writes n=%0d ok=%0d required n=32 ok=1", wa.size(), ok);
    end
    n_tests++;
    if ({if1.done, if1.error, if1.fetch_hold} !== 3'b101 || if1.word_count !== 20'd32) begin
      n_fail++;
      $display("FAIL vec_fit_end done/err/hold=%b count=%0d required 101 count=32",
               {if1.done, if1.error, if1.fetch_hold}, if1.word_count);
    end
    // Overrun: 33rd word has nowhere to go.
    wa.delete(); wd.delete();
    pulse_start(1'b1);
    for (int i = 0; i < 32; i++) send_word(16'(16'hC100 + i), 1'b0);
    wait_end();
    n_tests++;
    if ({if1.done, if1.error, if1.fetch_hold, if1.in_ready} !== 4'b0110) begin
      n_fail++;
      $display("FAIL vec_overrun_end done/err/hold/rdy=%b required 0110",
               {if1.done, if1.error, if1.fetch_hold, if1.in_ready});
    end
    rdy_seen = 0;
    if1.in_valid = 1'b1; if1.in_data = 16'hDEAD; if1.in_last = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (if1.in_ready || if1.mem_we) rdy_seen++;
    end
    if1.in_valid = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (rdy_seen !== 0 || wa.size() !== 32 || if1.word_count !== 20'd32 || if1.error !== 1'b1) begin
      n_fail++;
      $display("FAIL vec_overrun_hold rdy=%0d writes=%0d count=%0d err=%b required 0/32/32/1",
               rdy_seen, wa.size(), if1.word_count, if1.error);
    end
    n_tests++;
    if (wa.size() == 32 && wa[31] !== 20'd31) begin
      n_fail++;
      $display("FAIL vec_overrun_lastaddr got=%0d required=31", wa[31]);
    end
  endtask

  task automatic test_wr_cycles();
    int we_cnt;
    int bad;
    int t;
    logic first_we;
    if2.start = 1'b1; if2.vec_mode = 1'b0;
    @(posedge clk); #1;
    if2.start = 1'b0;
    if2.in_valid = 1'b1; if2.in_data = 16'h1234; if2.in_last = 1'b1;
    t = 0;
    @(negedge clk);
    while (!if2.in_ready && t < 20) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    if2.in_valid = 1'b0;
    we_cnt = 0; bad = 0;
    @(negedge clk);
    first_we = if2.mem_we;
    for (int i = 0; i < 12; i++) begin
      if (if2.mem_we) begin
        we_cnt++;
        if (if2.mem_addr !== 20'd32 || if2.mem_wdata !== 16'h1234 || if2.in_ready) bad++;
      end
      @(negedge clk);
    end
    n_tests++;
    if (first_we !== 1'b1) begin
      n_fail++;
      $display("FAIL wr6_latency mem_we=%b required=1", first_we);
    end
    n_tests++;
    if (we_cnt !== 6 || bad !== 0) begin
      n_fail++;
      $display("FAIL wr6_we_cycles got=%0d bad=%0d required 6/0", we_cnt, bad);
    end
    n_tests++;
    if ({if2.done, if2.error, if2.fetch_hold} !== 3'b100 || if2.word_count !== 20'd1) begin
      n_fail++;
      $display("FAIL wr6_end done/err/hold=%b count=%0d required 100 count=1",
               {if2.done, if2.error, if2.fetch_hold}, if2.word_count);
    end
  endtask

  task automatic test_back_to_back();
    int ok;
    wa.delete(); wd.delete();
    pulse_start(1'b0);
    for (int i = 0; i < 8; i++) begin
      if1.in_data = 16'(16'hC000 + i);
      repeat ($urandom_range(0, 3)) begin
        if1.start = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      if1.start = 1'($urandom_range(0, 1));
      if1.vec_mode = 1'b1;
      send_word(16'(16'hC000 + i), i == 7);
      if1.start = 1'b0;
    end
    wait_end();
    ok = (wa.size() == 8);
    for (int i = 0; i < 8 && i < wa.size(); i++)
      if (wa[i] !== 20'(32 + i) || wd[i] !== 16'(16'hC000 + i)) ok = 0;
    n_tests++;
    if (ok != 1) begin
      n_fail++;
      $display("FAIL b2b_writes n=%0d ok=%0d required n=8 ok=1", wa.size(), ok);
    end
    n_tests++;
    if ({if1.done, if1.fetch_hold} !== 2'b10 || if1.word_count !== 20'd8) begin
      n_fail++;
      $display("FAIL b2b_end done/hold=%b count=%0d required 10 count=8",
               {if1.done, if1.fetch_hold}, if1.word_count);
    end
  endtask

  task automatic test_reset_mid_write();
    pulse_start(1'b0);
    send_word(16'h5551, 1'b0);
    send_word(16'h5552, 1'b0);
    n_tests++;
    if (if1.mem_we !== 1'b1 || if1.word_count !== 20'd1) begin
      n_fail++;
      $display("FAIL midrst_pre we=%b count=%0d required we=1 count=1", if1.mem_we, if1.word_count);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_tests++;
    if ({if1.mem_we, if1.in_ready, if1.fetch_hold, if1.done} !== 4'b0010 || if1.word_count !== 20'd0) begin
      n_fail++;
      $display("FAIL midrst_after we/rdy/hold/done=%b count=%0d required 0010 count=0",
               {if1.mem_we, if1.in_ready, if1.fetch_hold, if1.done}, if1.word_count);
    end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (if1.in_ready !== 1'b0 || if1.mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_idle rdy=%b we=%b required 0/0", if1.in_ready, if1.mem_we);
    end
    wa.delete(); wd.delete();
    pulse_start(1'b0);
    send_word(16'h7777, 1'b1);
    wait_end();
    n_tests++;
    if (wa.size() !== 1 || (wa.size() == 1 && (wa[0] !== 20'd32 || wd[0] !== 16'h7777))) begin
      n_fail++;
      $display("FAIL midrst_restart n=%0d addr=%0d required n=1 addr=32 data=7777",
               wa.size(), (wa.size() > 0) ? wa[0] : 20'hFFFFF);
    end
    n_tests++;
    if (if1.word_count !== 20'd1 || if1.done !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_restart_end count=%0d done=%b required 1/1", if1.word_count, if1.done);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    prev_we = 1'b0;
    reset   = 1'b1;
    if1.start = 1'b0; if1.vec_mode = 1'b0; if1.in_valid = 1'b0;
    if1.in_data = '0; if1.in_last = 1'b0;
    if2.start = 1'b0; if2.vec_mode = 1'b0; if2.in_valid = 1'b0;
    if2.in_data = '0; if2.in_last = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_program_load();
    test_vector_region();
    test_wr_cycles();
    test_back_to_back();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
